uart_script_player: RTL and testbench

- Synthesizable, parametrised generator of UART register-write streams.
- Replays a stored script of serial bytes and programmed delays on a TX line.
- Drives the APU register-write UART input of fpga_top for on-board self-test (power-on jingle, 400 Hz tones, sfx sequences), with no host attached.
- Generalises fixed byte-by-byte stimulus with configurable baud, frame format, script depth, wait opcodes and looping.

---
 rtl/uart_script_player.sv | 203 ++++++++++++++++++++
 tb/tb_uart_script_player.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_script_player.sv
// uart_script_player: replays a stored script of UART bytes and timed waits on tx.
// Entries are {op[1:0], arg[7:0]}; DIV = CLK_HZ/BAUD must be at least 2, DEPTH a power of two.
module uart_script_player #(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 64,
  parameter int WAIT_UNIT = 12000,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [9:0]    wr_data,
  input  logic          start,
  input  logic          abort,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ptr
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int BCW  = $clog2(DIV);
  localparam int WMAX = 255 * WAIT_UNIT;
  localparam int WCW  = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int BIW  = 3;

  typedef enum logic [1:0] {
    OP_SEND = 2'b00,
    OP_WAIT = 2'b01,
    OP_END  = 2'b10,
    OP_LOOP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT,
    ST_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 tx_q, tx_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [BIW-1:0]       bit_q, bit_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [9:0]           mem [DEPTH];
  logic [9:0]           rd_q;
  op_e                  op;
  logic [7:0]           arg;
  logic                 baud_end;
  logic                 advance;
  logic [WCW-1:0]       wait_load;

  assign op        = op_e'(rd_q[9:8]);
  assign arg       = rd_q[7:0];
  assign baud_end  = (baud_q == BCW'(DIV - 1));
  // Counter is loaded with N-1 so the WAIT state lasts exactly arg*WAIT_UNIT cycles.
  assign wait_load = (arg == 8'd0) ? '0 : WCW'(int'(arg) * WAIT_UNIT - 1);

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FINISH);
  assign ptr  = ptr_q;

  // Script RAM: writes only while idle, registered read issued in FETCH.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    if (state_q == ST_FETCH) rd_q <= mem[ptr_q];
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    shift_d = shift_q;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          ptr_d   = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        case (op)
          OP_SEND: begin
            shift_d = arg[DATA_BITS-1:0];
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = ST_START;
          end
          OP_WAIT: begin
            wait_d  = wait_load;
            state_d = ST_WAIT;
          end
          OP_END:  state_d = ST_FINISH;
          default: begin
            ptr_d   = '0;
            state_d = ST_FETCH;
          end
        endcase
      end

      ST_START: begin
        baud_d = baud_end ? '0 : baud_q + BCW'(1);
        if (baud_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        baud_d = baud_end ? '0 : baud_q + BCW'(1);
        if (baud_end) begin
          if (bit_q == BIW'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIW'(1);
          end
        end
      end

      ST_STOP: begin
        baud_d = baud_end ? '0 : baud_q + BCW'(1);
        if (baud_end) begin
          if (bit_q == BIW'(STOP_BITS - 1)) advance = 1'b1;
          else bit_d = bit_q + BIW'(1);
        end
      end

      ST_WAIT: begin
        if (wait_q == '0) advance = 1'b1;
        else wait_d = wait_q - WCW'(1);
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Running off the last entry behaves like an END.
    if (advance) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_FINISH;
      end else begin
        ptr_d   = ptr_q + AW'(1);
        state_d = ST_FETCH;
      end
    end

    if (abort) begin
      state_d = ST_IDLE;
      tx_d    = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_script_player.sv
// Bench for uart_script_player: two instances (8N1 and 7-data/2-stop) at DIV=16, frames
// checked cycle-by-cycle against a queue of expected bytes and start cycles.
module tb_uart_script_player;
  localparam int DIV = 16;
  localparam int U   = 4;
  localparam int FA  = (1 + 8 + 1) * DIV;
  localparam int FB  = (1 + 7 + 2) * DIV;
  localparam logic [1:0] OP_SEND = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_LOOP = 2'b11;

  typedef struct {
    logic [7:0] val;
    int         t;
    bit         cut;
  } exp_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       abort   = 1'b0;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [1:0] ptr_a, ptr_b;

  int   cyc = 0;
  int   done_cnt_a = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  uart_script_player #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1),
                       .DEPTH(4), .WAIT_UNIT(U)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_a), .abort(abort), .tx(tx_a), .busy(busy_a), .done(done_a), .ptr(ptr_a));

  uart_script_player #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .STOP_BITS(2),
                       .DEPTH(4), .WAIT_UNIT(U)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_b), .abort(abort), .tx(tx_b), .busy(busy_b), .done(done_b), .ptr(ptr_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks one frame starting at the current cycle against the next queued expectation.
  task automatic mon(input bit sel, input int db, input int sb);
    exp_t e;
    int   t0, n, idx;
    bit   bad, cut;
    logic lvl, bsy, want;
    t0  = cyc;
    n   = (1 + db + sb) * DIV;
    bad = 1'b0;
    cut = 1'b0;
    e   = '{val: 8'h00, t: -1, cut: 1'b0};
    if (sel) begin
      if (exp_b.size() > 0) e = exp_b.pop_front();
    end else begin
      if (exp_a.size() > 0) e = exp_a.pop_front();
    end
    chk($sformatf("frame%0d_start_cycle", sel), t0, e.t);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      lvl = sel ? tx_b : tx_a;
      bsy = sel ? busy_b : busy_a;
      if (bsy !== 1'b1) begin
        cut = 1'b1;
        break;
      end
      idx  = k / DIV;
      want = (idx == 0) ? 1'b0 : (idx <= db) ? e.val[idx-1] : 1'b1;
      if (lvl !== want) bad = 1'b1;
    end
    chk($sformatf("frame%0d_bits_%0h", sel, e.val), bad, 0);
    chk($sformatf("frame%0d_truncated", sel), cut, e.cut);
  endtask

  always begin
    @(negedge clk);
    if (tx_a === 1'b0 && busy_a === 1'b1) mon(1'b0, 8, 1);
  end

  always begin
    @(negedge clk);
    if (tx_b === 1'b0 && busy_b === 1'b1) mon(1'b1, 7, 2);
  end

  task automatic wr(input int a, input logic [1:0] op, input logic [7:0] arg);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = a[1:0];
    wr_data = {op, arg};
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic go(input bit sel, output int s);
    @(posedge clk); #1;
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    int s, t, t2, w, dc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_ptr_a", ptr_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_ptr_b", ptr_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single frame: start bit at s+3, done two cycles after the stop bit.
    wr(0, OP_SEND, 8'h82);
    wr(1, OP_END, 8'h00);
    go(1'b0, s);
    exp_a.push_back('{8'h82, s + 3, 1'b0});
    wait_done(1'b0, t);
    chk("t1_done_cycle", t, s + 3 + FA + 2);
    @(negedge clk);
    chk("t1_busy_after", busy_a, 0);
    chk("t1_done_one_cycle", done_a, 0);
    chk("t1_ptr_hold", ptr_a, 1);

    // Back-to-back frames; a second start pulse mid-playback must be ignored.
    wr(0, OP_SEND, 8'h3F);
    wr(1, OP_SEND, 8'h89);
    wr(2, OP_END, 8'h00);
    go(1'b0, s);
    exp_a.push_back('{8'h3F, s + 3, 1'b0});
    exp_a.push_back('{8'h89, s + 3 + FA + 2, 1'b0});
    wait_cyc(s + 60);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, t);
    chk("t2_done_cycle", t, s + 3 + 2 * FA + 4);

    // WAIT entry: fetch/decode of the WAIT (2) and of the next SEND (2) plus the
    // WAIT state itself, which lasts arg*WAIT_UNIT cycles or 1 cycle for arg=0.
    for (int j = 0; j < 2; j++) begin
      w = (j == 0) ? 3 : 0;
      wr(0, OP_SEND, 8'h05);
      wr(1, OP_WAIT, 8'(w));
      wr(2, OP_SEND, 8'h9D);
      wr(3, OP_END, 8'h00);
      go(1'b0, s);
      t2 = s + 3 + FA + 4 + ((w * U > 0) ? w * U : 1);
      exp_a.push_back('{8'h05, s + 3, 1'b0});
      exp_a.push_back('{8'h9D, t2, 1'b0});
      wait_done(1'b0, t);
      chk($sformatf("t3_wait%0d_done_cycle", w), t, t2 + FA + 2);
    end

    // No END: passing the last entry finishes right after the 4th stop bit.
    wr(0, OP_SEND, 8'h11);
    wr(1, OP_SEND, 8'h22);
    wr(2, OP_SEND, 8'hC3);
    wr(3, OP_SEND, 8'h7E);
    go(1'b0, s);
    exp_a.push_back('{8'h11, s + 3, 1'b0});
    exp_a.push_back('{8'h22, s + 3 + (FA + 2), 1'b0});
    exp_a.push_back('{8'hC3, s + 3 + 2 * (FA + 2), 1'b0});
    exp_a.push_back('{8'h7E, s + 3 + 3 * (FA + 2), 1'b0});
    wait_done(1'b0, t);
    chk("t4_done_cycle", t, s + 3 + 3 * (FA + 2) + FA);
    chk("t4_ptr_last", ptr_a, 3);
    @(negedge clk);
    chk("t4_busy_after", busy_a, 0);

    // LOOP with abort in the 3rd frame; a write during playback must be dropped.
    wr(0, OP_SEND, 8'hAA);
    wr(1, OP_LOOP, 8'h00);
    dc = done_cnt_a;
    go(1'b0, s);
    exp_a.push_back('{8'hAA, s + 3, 1'b0});
    exp_a.push_back('{8'hAA, s + 3 + (FA + 4), 1'b0});
    exp_a.push_back('{8'hAA, s + 3 + 2 * (FA + 4), 1'b1});
    wait_cyc(s + 3 + (FA + 4) + 30);
    wr(0, OP_SEND, 8'h55);
    wait_cyc(s + 3 + 2 * (FA + 4) + 80);
    pulse_abort();
    @(negedge clk);
    chk("t5_abort_tx", tx_a, 1);
    chk("t5_abort_busy", busy_a, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_done", done_cnt_a, dc);
    go(1'b0, s);
    exp_a.push_back('{8'hAA, s + 3, 1'b0});
    exp_a.push_back('{8'hAA, s + 3 + (FA + 4), 1'b1});
    wait_cyc(s + 3 + (FA + 4) + 40);
    pulse_abort();
    @(negedge clk);
    chk("t5_replay_abort_busy", busy_a, 0);
    chk("t5_replay_abort_tx", tx_a, 1);

    // abort together with start: playback must not begin.
    @(posedge clk); #1;
    abort   = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    abort   = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    chk("t5_abort_start_busy", busy_a, 0);
    repeat (10) @(negedge clk);
    chk("t5_abort_start_idle", busy_a, 0);
    chk("t5_abort_start_done_cnt", done_cnt_a, dc);

    // Reset mid-frame drives tx high on the next cycle.
    go(1'b0, s);
    exp_a.push_back('{8'hAA, s + 3, 1'b1});
    wait_cyc(s + 50);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx_a, 1);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_ptr", ptr_a, 0);

    // 7 data bits, 2 stop bits: bit 7 of arg is never sent, frame is 10 bit periods.
    wr(0, OP_SEND, 8'hFF);
    wr(1, OP_SEND, 8'h95);
    wr(2, OP_END, 8'h00);
    go(1'b1, s);
    exp_b.push_back('{8'hFF & 8'h7F, s + 3, 1'b0});
    exp_b.push_back('{8'h95 & 8'h7F, s + 3 + FB + 2, 1'b0});
    wait_done(1'b1, t);
    chk("t6_done_cycle", t, s + 3 + 2 * FB + 4);
    chk("t6_ptr", ptr_b, 2);
    @(negedge clk);
    chk("t6_busy_after", busy_b, 0);

    repeat (5) @(negedge clk);
    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
